// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: scan chain with capture, hold, manual shift, automatic burst shift and shadow update register
module scan_chain_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SE,
  input  logic             SD,
  input  logic [WIDTH-1:0] D,
  input  logic             HOLD,
  input  logic             start,
  input  logic             UPD,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic [WIDTH-1:0] QU,
  output logic             busy,
  output logic             done
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  assign SO = Q[WIDTH-1];
  // chain, shadow register and burst controller; busy/done registered alongside the state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      Q     <= '0;
      QU    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (UPD && state == IDLE) QU <= Q;
      if (state == SHIFT) begin
        Q   <= {Q[WIDTH-2:0], SD};
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end else begin
        Q <= SE ? {Q[WIDTH-2:0], SD} : HOLD ? Q : D;
        if (start) begin
          state <= SHIFT;
          busy  <= 1'b1;
          cnt   <= CNT_W'(WIDTH);
        end
      end
    end
endmodule
